// File: rtl/pid_pkg.sv
// Shared PID definitions: default widths, FSM state type, saturation limits
// and a saturating narrow helper usable by every PID path.
package pid_pkg;

  localparam int unsigned E_W     = 6;
  localparam int unsigned K_W     = 6;
  localparam int unsigned D_OUT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } pid_state_e;

  // Limits for the default output width.
  localparam int SAT_HI = (1 <<< (D_OUT_W - 1)) - 1;
  localparam int SAT_LO = -(1 <<< (D_OUT_W - 1));

  // Clip a signed value into the range of an out_w-bit two's-complement word.
  function automatic logic signed [31:0] sat_clip(input logic signed [31:0] x,
                                                  input int unsigned out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 32'd1));
    if (x > hi) begin
      sat_clip = hi;
    end else if (x < lo) begin
      sat_clip = lo;
    end else begin
      sat_clip = x;
    end
  endfunction

endpackage

// File: rtl/differentiator_seq_mult_signed.sv
// Repeated-addition multiplier: signed multiplicand times unsigned multiplier.
// start_i loads operands and clears the accumulator; each step_i adds the
// multiplicand once and decrements the remaining count. last_c flags that the
// current step is the final one.
module seq_mult_signed #(
  parameter int unsigned MW = 7,
  parameter int unsigned KW = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       step_i,
  input  logic signed [MW-1:0]       mcand_i,
  input  logic        [KW-1:0]       mplier_i,
  output logic signed [MW+KW-1:0]    prod_o,
  output logic                       last_c
);

  localparam int unsigned AW = MW + KW;

  logic signed [AW-1:0] acc_q;
  logic signed [MW-1:0] mcand_q;
  logic        [KW-1:0] count_q;

  // Load operands on start, accumulate one multiplicand per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else if (start_i) begin
      acc_q   <= '0;
      mcand_q <= mcand_i;
      count_q <= mplier_i;
    end else if (step_i) begin
      acc_q   <= acc_q + AW'(mcand_q);
      count_q <= count_q - KW'(1);
    end
  end

  assign prod_o = acc_q;
  assign last_c = (count_q == KW'(1));

endmodule

// File: rtl/differentiator.sv
// Derivative term of the PID controller: first difference of successive
// error samples scaled by K_d through a sequential multiplier.
// Build option: define DIFFERENTIATOR_SAT_EN to saturate the output instead
// of wrapping it to OUT_W bits.
module differentiator
  import pid_pkg::*;
#(
  parameter int unsigned W     = E_W,
  parameter int unsigned KW    = K_W,
  parameter int unsigned OUT_W = D_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    e_valid,
  input  logic signed [W-1:0]     e,
  input  logic        [KW-1:0]    K_d,
  output logic                    busy,
  output logic                    d_valid,
  output logic signed [OUT_W-1:0] d_contrib
);

  localparam int unsigned DW = W + 1;
  localparam int unsigned AW = DW + KW;

  pid_state_e state_q, state_d;

  logic signed [W-1:0]     e_prev_q;
  logic                    first_q;
  logic                    busy_q;
  logic                    d_valid_q;
  logic signed [OUT_W-1:0] d_contrib_q, d_contrib_d;

  logic                    start;
  logic                    step;
  logic signed [DW-1:0]    diff;
  logic signed [AW-1:0]    prod;
  logic                    last_c;

`ifdef DIFFERENTIATOR_SAT_EN
  function automatic logic signed [OUT_W-1:0] convert(input logic signed [AW-1:0] x);
    convert = OUT_W'(sat_clip(32'(x), OUT_W));
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] convert(input logic signed [AW-1:0] x);
    convert = x[OUT_W-1:0];
  endfunction
`endif

  // The first sample after reset has no predecessor, so it contributes no kick.
  assign diff = first_q ? '0 : (DW'(e) - DW'(e_prev_q));

  seq_mult_signed #(
    .MW (DW),
    .KW (KW)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .step_i   (step),
    .mcand_i  (diff),
    .mplier_i (K_d),
    .prod_o   (prod),
    .last_c   (last_c)
  );

  // Next-state and control; nothing advances while ena is low.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    step        = 1'b0;
    d_contrib_d = d_contrib_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (e_valid) begin
            start   = 1'b1;
            state_d = (K_d == '0) ? DONE : MULT;
          end
        end
        MULT: begin
          step = 1'b1;
          if (last_c) begin
            state_d = DONE;
          end
        end
        DONE: begin
          d_contrib_d = convert(prod);
          state_d     = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, sample history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      e_prev_q    <= '0;
      first_q     <= 1'b1;
      busy_q      <= 1'b0;
      d_valid_q   <= 1'b0;
      d_contrib_q <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      busy_q      <= (state_d != IDLE);
      d_valid_q   <= (state_d == DONE);
      d_contrib_q <= d_contrib_d;
      if (start) begin
        e_prev_q <= e;
        first_q  <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  assign d_valid   = d_valid_q;
  assign d_contrib = d_contrib_q;

endmodule
